// File: rtl/rvmmio_bus.sv
// Data-side interconnect: RAM passthrough, FIFO-buffered 8N1 UART TX and optional 64-bit timer.
// Define RVMMIO_TIMER_EN to build the cycle timer; otherwise TIMER reads return 0.
module rvmmio_bus #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_en,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_d,
    input  logic [3:0]  dmem_we,
    output logic [31:0] dmem_q,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_d,
    output logic [3:0]  ram_we,
    input  logic [31:0] ram_q,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_MMIO} sel_t;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic        w_sel_ram, w_sel_mmio, w_is_rd;
    logic [1:0]  w_off;
    logic        w_push_req, w_push_ok, w_pop, w_ovf_clr;
    logic        w_full, w_empty, w_busy;
    logic [7:0]  w_head, w_level8;
    logic [31:0] w_status, w_timer_lo, w_timer_hi, w_mmio_rdata;

    assign w_sel_ram  = (dmem_addr[31:28] == 4'h0);
    assign w_sel_mmio = (dmem_addr[31:28] == 4'h1);
    assign w_off      = dmem_addr[3:2];
    assign w_is_rd    = (dmem_we == 4'h0);

    assign ram_en   = dmem_en & w_sel_ram;
    assign ram_addr = dmem_addr;
    assign ram_d    = dmem_d;
    assign ram_we   = w_sel_ram ? dmem_we : 4'h0;

    // ---------------- TX FIFO ----------------
    logic [7:0]    r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;

    assign w_full     = (r_level == DEPTH_L);
    assign w_empty    = (r_level == '0);
    assign w_push_req = dmem_en & w_sel_mmio & (w_off == 2'd0) & dmem_we[0];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_ovf_clr  = dmem_en & w_sel_mmio & (w_off == 2'd1) & dmem_we[0] & dmem_d[3];
    assign w_head     = r_fifo_mem[r_rptr];
    assign w_level8   = 8'(r_level);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_mem[r_wptr] <= dmem_d[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_push_req & ~w_push_ok) r_ovf <= 1'b1;
            else if (w_ovf_clr)          r_ovf <= 1'b0;
        end
    end

    // ---------------- Transmitter ----------------
    state_t        r_state, w_state_next;
    logic [DW-1:0] r_div, w_div_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_tx, w_tx_next;

    assign w_busy  = (r_state != ST_IDLE);
    assign uart_tx = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        // The line is driven from the previous state, one cycle behind the FSM.
        case (r_state)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = r_shift[0];
            default:  w_tx_next = 1'b1;
        endcase
        case (r_state)
            ST_IDLE: begin
                w_div_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_next = ST_STOP;
                    else               w_bit_next   = r_bit + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_div == DIV_LAST) begin
                    w_div_next = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- Timer ----------------
`ifdef RVMMIO_TIMER_EN
    logic [63:0] r_timer;
    logic [31:0] r_tmr_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer      <= '0;
            r_tmr_shadow <= '0;
        end else begin
            r_timer <= r_timer + 64'd1;
            // Latching hi on the lo read makes a lo-then-hi pair coherent.
            if (dmem_en & w_sel_mmio & w_is_rd & (w_off == 2'd2)) begin
                r_tmr_shadow <= r_timer[63:32];
            end
        end
    end

    assign w_timer_lo = r_timer[31:0];
    assign w_timer_hi = r_tmr_shadow;
`else
    assign w_timer_lo = 32'd0;
    assign w_timer_hi = 32'd0;
`endif

    // ---------------- Read return ----------------
    sel_t        r_sel;
    logic [31:0] r_mmio_q;

    assign w_status = {16'd0, w_level8, 4'd0, r_ovf, w_busy, w_empty, w_full};

    always_comb begin
        case (w_off)
            2'd1:    w_mmio_rdata = w_status;
            2'd2:    w_mmio_rdata = w_timer_lo;
            2'd3:    w_mmio_rdata = w_timer_hi;
            default: w_mmio_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= SEL_NONE;
            r_mmio_q <= '0;
        end else begin
            if (dmem_en & w_is_rd & w_sel_ram)       r_sel <= SEL_RAM;
            else if (dmem_en & w_is_rd & w_sel_mmio) r_sel <= SEL_MMIO;
            else                                     r_sel <= SEL_NONE;
            if (dmem_en & w_is_rd & w_sel_mmio) r_mmio_q <= w_mmio_rdata;
        end
    end

    always_comb begin
        case (r_sel)
            SEL_RAM:  dmem_q = ram_q;
            SEL_MMIO: dmem_q = r_mmio_q;
            default:  dmem_q = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_rvmmio_bus.sv
// Randomised bench for rvmmio_bus: a queue/time-based reference model feeds scoreboards
// for bus read data and for UART frames decoded off the serial line.
module tb_rvmmio_bus;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;
    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_TMR_LO = 32'h1000_0008;
    localparam logic [31:0] A_TMR_HI = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmem_en = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_d = '0;
    logic [3:0]  dmem_we = '0;
    logic [31:0] dmem_q;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_d;
    logic [3:0]  ram_we;
    logic [31:0] ram_q = '0;
    logic        uart_tx;

    always #5 clk = ~clk;

    rvmmio_bus #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .dmem_en(dmem_en), .dmem_addr(dmem_addr),
        .dmem_d(dmem_d), .dmem_we(dmem_we), .dmem_q(dmem_q), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
        .uart_tx(uart_tx)
    );

    // External synchronous RAM with one-cycle read latency
    logic [31:0] ram_arr [256] = '{default: 32'd0};
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_arr[ram_addr[9:2]][b*8 +: 8] <= ram_d[b*8 +: 8];
            ram_q <= ram_arr[ram_addr[9:2]];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct { bit [7:0] b; int unsigned start; } frame_t;
    int unsigned e_cnt = 0;
    int unsigned tx_free = 0;
    bit [7:0]    fifo_m[$];
    frame_t      frame_q[$];
    bit [31:0]   rd_exp_q[$];
    bit [31:0]   rd_addr_q[$];
    bit [31:0]   mem_m [int];
    bit          ovf_m = 1'b0;
    bit [63:0]   tcount = '0;
    bit [31:0]   shadow_m = '0;
    bit          rd_pending = 1'b0;

    always @(posedge clk) begin
        int     sz;
        bit     popped, ovf_set, busy;
        bit [31:0] exp_v, cur;
        frame_t fr;
        e_cnt++;
        rd_pending = rst_n && dmem_en && (dmem_we == 4'h0);
        if (!rst_n) begin
            fifo_m.delete();
            frame_q.delete();
            ovf_m = 0; tcount = 0; shadow_m = 0; tx_free = 0;
        end else begin
            sz = fifo_m.size();
            popped = 0; ovf_set = 0;
            busy = (e_cnt <= tx_free);
            if (rd_pending) begin
                exp_v = 32'd0;
                if (dmem_addr[31:28] == 4'h0) begin
                    if (mem_m.exists(int'(dmem_addr))) exp_v = mem_m[int'(dmem_addr)];
                end else if (dmem_addr[31:28] == 4'h1) begin
                    case (dmem_addr[3:2])
                        2'd1: exp_v = {16'h0, 8'(sz), 4'h0, ovf_m, busy, sz == 0, sz == DEPTH};
`ifdef RVMMIO_TIMER_EN
                        2'd2: exp_v = tcount[31:0];
                        2'd3: exp_v = shadow_m;
`endif
                        default: exp_v = 32'd0;
                    endcase
                end
                rd_exp_q.push_back(exp_v);
                rd_addr_q.push_back(dmem_addr);
            end
            // Transmitter takes a byte once the previous frame's full 10 bit-times are over
            if (sz > 0 && e_cnt >= tx_free) begin
                fr.b = fifo_m.pop_front();
                fr.start = e_cnt + 1;
                frame_q.push_back(fr);
                tx_free = e_cnt + FRAME;
                popped = 1;
            end
            if (dmem_en && dmem_addr[31:28] == 4'h1 && dmem_addr[3:2] == 2'd0 && dmem_we[0]) begin
                if (sz < DEPTH || popped) fifo_m.push_back(dmem_d[7:0]);
                else ovf_set = 1;
            end
            if (ovf_set) ovf_m = 1;
            else if (dmem_en && dmem_addr[31:28] == 4'h1 && dmem_addr[3:2] == 2'd1 &&
                     dmem_we[0] && dmem_d[3]) ovf_m = 0;
            if (dmem_en && dmem_addr[31:28] == 4'h0 && dmem_we != 4'h0) begin
                cur = mem_m.exists(int'(dmem_addr)) ? mem_m[int'(dmem_addr)] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (dmem_we[b]) cur[b*8 +: 8] = dmem_d[b*8 +: 8];
                mem_m[int'(dmem_addr)] = cur;
            end
            if (rd_pending && dmem_addr[31:28] == 4'h1 && dmem_addr[3:2] == 2'd2)
                shadow_m = tcount[63:32];
            tcount++;
        end
    end

    // ---------------- Read-data monitor ----------------
    bit [31:0] last_lo = '0;
    bit        have_lo = 1'b0;
    always @(negedge clk) begin
        bit [31:0] ev, ea;
        if (rd_pending) begin
            if (rd_exp_q.size() == 0) begin
                chk("rd_unexpected", 64'(dmem_q), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ev = rd_exp_q.pop_front();
                ea = rd_addr_q.pop_front();
                chk("rdata", 64'(dmem_q), 64'(ev));
                $display("rd   addr=%08h q=%08h exp=%08h", ea, dmem_q, ev);
`ifdef RVMMIO_TIMER_EN
                if (ea == A_TMR_LO) begin
                    if (have_lo) chk("timer_mono", 64'(dmem_q > last_lo), 64'd1);
                    last_lo = dmem_q;
                    have_lo = 1'b1;
                end
`endif
            end
        end
    end

    // ---------------- UART receiver ----------------
    bit          rx_active = 1'b0;
    int unsigned rx_start = 0;
    bit [7:0]    rx_byte = '0;
    always @(negedge clk) begin
        int unsigned t;
        frame_t fr;
        if (!rst_n) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (uart_tx == 1'b0) begin
                rx_active = 1; rx_start = e_cnt; rx_byte = '0;
            end
        end else begin
            t = e_cnt - rx_start;
            if (t == DIV / 2) begin
                chk("start_bit", 64'(uart_tx), 64'd0);
            end else if (t >= DIV + DIV / 2 && t < 9 * DIV && (t - DIV / 2) % DIV == 0) begin
                rx_byte[(t - DIV / 2) / DIV - 1] = uart_tx;
            end else if (t == 9 * DIV + DIV / 2) begin
                chk("stop_bit", 64'(uart_tx), 64'd1);
                rx_active = 0;
                if (frame_q.size() == 0) begin
                    chk("frame_spurious", 64'(rx_byte), 64'hFFFF);
                end else begin
                    fr = frame_q.pop_front();
                    chk("frame_start", 64'(rx_start), 64'(fr.start));
                    chk("frame_byte", 64'(rx_byte), 64'(fr.b));
                    $display("uart byte=%02h exp=%02h start=%0d exp_start=%0d", rx_byte, fr.b, rx_start, fr.start);
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        logic sel;
        dmem_en = 1'b1; dmem_addr = a; dmem_d = d; dmem_we = we;
        sel = (a[31:28] == 4'h0);
        #1;
        chk("ram_en", 64'(ram_en), 64'(sel));
        chk("ram_we", 64'(ram_we), sel ? 64'(we) : 64'd0);
        chk("ram_addr", 64'(ram_addr), 64'(a));
        @(posedge clk); #1;
        dmem_en = 1'b0; dmem_we = 4'h0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        #2_000_000;
        chk("watchdog_expired", 64'd1, 64'd0);
        summary();
        $finish;
    end

    initial begin
        logic [31:0] a;
        int op;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dmem_q", 64'(dmem_q), 64'd0);
        chk("reset_uart_tx", 64'(uart_tx), 64'd1);
        chk("reset_ram_en", 64'(ram_en), 64'd0);
        chk("reset_ram_we", 64'(ram_we), 64'd0);
        rst_n = 1'b1;

        bus(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        bus(32'h0000_0010, 32'h0, 4'h0);
        idle(2);
        bus(32'h2000_0000, 32'h0, 4'h0);
        bus(32'h3000_0004, 32'h1234_5678, 4'hF);
        bus(A_STATUS, 32'h0, 4'h0);

        bus(A_TXDATA, 32'h55, 4'h1);
        idle(3);
        bus(A_STATUS, 32'h0, 4'h0);
        idle(FRAME + 5);

        bus(A_TXDATA, 32'h01, 4'h1);
        bus(A_TXDATA, 32'h80, 4'h1);
        idle(2 * FRAME + 5);

        for (int i = 0; i < 6; i++) bus(A_TXDATA, 32'(8'hA0 + i), 4'h1);
        bus(A_STATUS, 32'h0, 4'h0);
        bus(A_STATUS, 32'h8, 4'h1);
        bus(A_STATUS, 32'h0, 4'h0);
        idle(FRAME * (DEPTH + 2));

        bus(A_TMR_LO, 32'h0, 4'h0);
        bus(A_TMR_HI, 32'h0, 4'h0);
        idle(7);
        bus(A_TMR_LO, 32'hFFFF_FFFF, 4'hF);
        bus(A_TMR_LO, 32'h0, 4'h0);
        bus(A_TMR_HI, 32'h0, 4'h0);

        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: bus({22'd0, 8'($urandom), 2'b00}, $urandom, 4'($urandom_range(1, 15)));
                3, 4:    bus({22'd0, 8'($urandom_range(0, 15)), 2'b00}, 32'h0, 4'h0);
                5:       bus(A_TXDATA, $urandom, 4'($urandom));
                6:       bus(A_STATUS, $urandom, 4'($urandom_range(0, 1)));
                7:       bus($urandom_range(0, 1) ? A_TMR_LO : A_TMR_HI, 32'h0, 4'h0);
                default: begin
                    a = {4'($urandom_range(2, 15)), 26'($urandom), 2'b00};
                    bus(a, $urandom, 4'($urandom));
                end
            endcase
            idle(int'($urandom_range(0, 3)));
        end
        idle(FRAME * (DEPTH + 2));

        bus(A_TXDATA, 32'hA5, 4'h1);
        idle(15);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_tx", 64'(uart_tx), 64'd1);
        chk("midframe_reset_q", 64'(dmem_q), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bus(A_STATUS, 32'h0, 4'h0);
        idle(FRAME + 10);

        @(negedge clk); #1;
        chk("leftover_reads", 64'(rd_exp_q.size()), 64'd0);
        chk("leftover_frames", 64'(frame_q.size()), 64'd0);
        summary();
        $finish;
    end
endmodule
